// File: rtl/conv3d_wprefetch_pkg.sv
// Shared types and helpers for the conv3d weight prefetch engine.
package conv3d_wprefetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned REM_W = 9;
   localparam int unsigned PTR_W = 8;

   // Byte-per-word shift: log2 of the word size in bytes.
   function automatic int unsigned byte_shift(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/conv3d_wprefetch_if.sv
// Avalon-MM burst read bus between the weight prefetch engine and memory.
interface conv3d_wprefetch_if #(
   parameter int unsigned AW  = 30,
   parameter int unsigned DW  = 256,
   parameter int unsigned BCW = 5
);

   logic [AW-1:0]  avm_address;
   logic           avm_read;
   logic [BCW-1:0] avm_burstcount;
   logic           avm_waitrequest;
   logic [DW-1:0]  avm_readdata;
   logic           avm_readdatavalid;

   modport master (
      output avm_address, avm_read, avm_burstcount,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid
   );

   modport slave (
      input  avm_address, avm_read, avm_burstcount,
      output avm_waitrequest, avm_readdata, avm_readdatavalid
   );

endinterface

// File: rtl/conv3d_wprefetch.sv
// Weight prefetch engine: bursts cfg_length_w words from memory into the
// on-chip weight buffer starting at address 0, then pulses prefetch_done.
module conv3d_wprefetch
   import conv3d_wprefetch_pkg::*;
#(
   parameter int unsigned AW        = 30,
   parameter int unsigned DW        = 256,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned BCW       = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_prefetch,
   input  logic [AW-1:0]            cfg_waddr,
   input  logic [7:0]               cfg_length_w,
   conv3d_wprefetch_if.master       avm,
   output logic                     wbuf_we,
   output logic [PTR_W-1:0]         wbuf_addr,
   output logic [DW-1:0]            wbuf_data,
   output logic                     prefetch_busy,
   output logic                     prefetch_done
);

   localparam int unsigned      SH       = byte_shift(DW);
   localparam logic [AW-1:0]    LOW_MASK = AW'((64'd1 << SH) - 64'd1);
   localparam logic [REM_W-1:0] MAX_BC   = REM_W'(MAX_BURST);

   state_t           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [BCW-1:0]   beat_q, beat_d;

   logic             read_q, read_d;
   logic [AW-1:0]    address_q, address_d;
   logic [BCW-1:0]   bcount_q, bcount_d;
   logic             we_q, we_d;
   logic [PTR_W-1:0] waddr_q, waddr_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [AW-1:0]    base_addr;
   logic [REM_W-1:0] cfg_len9;

   function automatic logic [BCW-1:0] burst_of(input logic [REM_W-1:0] r);
      return (r > MAX_BC) ? MAX_BC[BCW-1:0] : r[BCW-1:0];
   endfunction

   assign base_addr = cfg_waddr & ~LOW_MASK;
   assign cfg_len9  = {1'b0, cfg_length_w};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         ptr_q     <= '0;
         beat_q    <= '0;
         read_q    <= 1'b0;
         address_q <= '0;
         bcount_q  <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         ptr_q     <= ptr_d;
         beat_q    <= beat_d;
         read_q    <= read_d;
         address_q <= address_d;
         bcount_q  <= bcount_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Avalon request fields are loaded on every transition into REQ so they
   // come straight from flops and stay frozen across waitrequest stalls.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      ptr_d     = ptr_q;
      beat_d    = beat_q;
      read_d    = read_q;
      address_d = address_q;
      bcount_d  = bcount_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cfg_prefetch) begin
               addr_d = base_addr;
               rem_d  = cfg_len9;
               ptr_d  = '0;
               if (cfg_length_w == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d   = ST_REQ;
                  read_d    = 1'b1;
                  address_d = base_addr;
                  bcount_d  = burst_of(cfg_len9);
               end
            end
         end
         ST_REQ: begin
            if (!avm.avm_waitrequest) begin
               read_d  = 1'b0;
               beat_d  = bcount_q;
               rem_d   = rem_q - REM_W'(bcount_q);
               addr_d  = addr_q + (AW'(bcount_q) << SH);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (avm.avm_readdatavalid) begin
               we_d    = 1'b1;
               waddr_d = ptr_q;
               wdata_d = avm.avm_readdata;
               ptr_d   = ptr_q + PTR_W'(1);
               beat_d  = beat_q - BCW'(1);
               if (beat_q == BCW'(1)) begin
                  if (rem_q != '0) begin
                     state_d   = ST_REQ;
                     read_d    = 1'b1;
                     address_d = addr_q;
                     bcount_d  = burst_of(rem_q);
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign avm.avm_read       = read_q;
   assign avm.avm_address    = address_q;
   assign avm.avm_burstcount = bcount_q;
   assign wbuf_we            = we_q;
   assign wbuf_addr          = waddr_q;
   assign wbuf_data          = wdata_q;
   assign prefetch_busy      = busy_q;
   assign prefetch_done      = done_q;

endmodule

// File: tb/tb_conv3d_wprefetch.sv
// Directed bench for conv3d_wprefetch with a latency-3 Avalon burst responder.
module tb_conv3d_wprefetch;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cfg_prefetch = 1'b0;
   logic [29:0]  cfg_waddr = '0;
   logic [7:0]   cfg_length_w = '0;
   logic         wbuf_we;
   logic [7:0]   wbuf_addr;
   logic [255:0] wbuf_data;
   logic         prefetch_busy;
   logic         prefetch_done;

   logic         wr = 1'b0;
   logic         rdv = 1'b0;
   logic [255:0] rdata = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned seq = 0;
   int unsigned stall_left = 0;
   int unsigned done_cnt = 0;
   int unsigned cyc = 0;
   int unsigned last_we_cyc = 0;
   int unsigned done_cyc = 0;

   logic [29:0]  req_addr[$];
   logic [4:0]   req_bc[$];
   logic [29:0]  st_addr[$];
   logic [4:0]   st_bc[$];
   logic [7:0]   wq_addr[$];
   logic [255:0] wq_data[$];

   conv3d_wprefetch_if #(.AW(30), .DW(256), .BCW(5)) bus ();

   assign bus.avm_waitrequest   = wr;
   assign bus.avm_readdatavalid = rdv;
   assign bus.avm_readdata      = rdata;

   conv3d_wprefetch #(.AW(30), .DW(256), .MAX_BURST(16), .BCW(5)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_prefetch  (cfg_prefetch),
      .cfg_waddr     (cfg_waddr),
      .cfg_length_w  (cfg_length_w),
      .avm           (bus),
      .wbuf_we       (wbuf_we),
      .wbuf_addr     (wbuf_addr),
      .wbuf_data     (wbuf_data),
      .prefetch_busy (prefetch_busy),
      .prefetch_done (prefetch_done)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] pat(input int unsigned s);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(s);
      return {8{w}};
   endfunction

   // Memory model: optional waitrequest stall, then beats 3 cycles after accept.
   initial begin : responder
      int unsigned lat;
      int unsigned beats;
      bit          pending;
      lat = 0; beats = 0; pending = 1'b0;
      forever begin
         @(negedge clk);
         rdv = 1'b0;
         if (rst) begin
            pending = 1'b0;
            wr      = 1'b0;
         end else if (pending) begin
            if (lat > 1) begin
               lat--;
            end else begin
               rdv   = 1'b1;
               rdata = pat(seq);
               seq++;
               beats--;
               if (beats == 0) pending = 1'b0;
            end
         end else if (bus.avm_read) begin
            if (stall_left > 0) begin
               wr = 1'b1;
               stall_left--;
               st_addr.push_back(bus.avm_address);
               st_bc.push_back(bus.avm_burstcount);
            end else begin
               wr = 1'b0;
               req_addr.push_back(bus.avm_address);
               req_bc.push_back(bus.avm_burstcount);
               pending = 1'b1;
               lat     = 3;
               beats   = bus.avm_burstcount;
            end
         end else begin
            wr = (stall_left != 0);
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (wbuf_we) begin
         wq_addr.push_back(wbuf_addr);
         wq_data.push_back(wbuf_data);
         last_we_cyc = cyc;
      end
      if (prefetch_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      req_addr.delete(); req_bc.delete();
      st_addr.delete();  st_bc.delete();
      wq_addr.delete();  wq_data.delete();
      done_cnt = 0;
      seq      = 0;
   endtask

   // Leaves the caller at the negedge of cycle N+1.
   task automatic start(input logic [29:0] addr, input logic [7:0] len);
      @(negedge clk);
      cfg_waddr    = addr;
      cfg_length_w = len;
      cfg_prefetch = 1'b1;
      @(negedge clk);
      cfg_prefetch = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int unsigned n;
      n = 0;
      while (prefetch_done !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, prefetch_done, 1'b1);
   endtask

   task automatic check_req(input string tag, input int unsigned idx,
                            input logic [29:0] addr, input logic [4:0] bc);
      check($sformatf("%s_req%0d_addr", tag, idx), req_addr[idx], addr);
      check($sformatf("%s_req%0d_bc", tag, idx), req_bc[idx], bc);
   endtask

   task automatic check_writes(input string tag, input int unsigned n);
      check({tag, "_nwrites"}, wq_addr.size(), n);
      for (int unsigned i = 0; i < n; i++) begin
         check($sformatf("%s_wr%0d_addr", tag, i), wq_addr[i], i);
         check($sformatf("%s_wr%0d_data", tag, i), wq_data[i], pat(i));
      end
   endtask

   initial begin : stim
      repeat (2) @(negedge clk);
      check("reset_ctrl", {bus.avm_read, bus.avm_address, bus.avm_burstcount, wbuf_we,
                           wbuf_addr, prefetch_busy, prefetch_done}, '0);
      check("reset_data", wbuf_data, '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single short burst
      clear_logs();
      start(30'h1000, 8'd5);
      check("t1_read", bus.avm_read, 1'b1);
      check("t1_busy", prefetch_busy, 1'b1);
      check("t1_addr", bus.avm_address, 30'h1000);
      check("t1_bc", bus.avm_burstcount, 5'd5);
      wait_done("t1");
      @(negedge clk);
      check("t1_busy_after", prefetch_busy, 1'b0);
      check("t1_done_pulse", prefetch_done, 1'b0);
      check("t1_done_timing", done_cyc, last_we_cyc + 1);
      check("t1_nreq", req_addr.size(), 1);
      check_req("t1", 0, 30'h1000, 5'd5);
      check_writes("t1", 5);
      check("t1_done_cnt", done_cnt, 1);

      // Multi-burst, 16 + 16 + 8
      clear_logs();
      start(30'h2000, 8'd40);
      wait_done("t2");
      repeat (2) @(negedge clk);
      check("t2_nreq", req_addr.size(), 3);
      check_req("t2", 0, 30'h2000, 5'd16);
      check_req("t2", 1, 30'h2200, 5'd16);
      check_req("t2", 2, 30'h2400, 5'd8);
      check_writes("t2", 40);
      check("t2_done_timing", done_cyc, last_we_cyc + 1);
      check("t2_done_cnt", done_cnt, 1);

      // Waitrequest stall of 4 cycles on the first request
      clear_logs();
      stall_left = 4;
      repeat (2) @(negedge clk);
      start(30'h3000, 8'd5);
      check("t3_read", bus.avm_read, 1'b1);
      wait_done("t3");
      @(negedge clk);
      check("t3_nstall", st_addr.size(), 4);
      for (int unsigned i = 0; i < 4; i++) begin
         check($sformatf("t3_stall%0d_addr", i), st_addr[i], 30'h3000);
         check($sformatf("t3_stall%0d_bc", i), st_bc[i], 5'd5);
      end
      check("t3_nreq", req_addr.size(), 1);
      check_req("t3", 0, 30'h3000, 5'd5);
      check_writes("t3", 5);

      // Zero length
      clear_logs();
      start(30'h3300, 8'd0);
      check("t4_busy_n1", prefetch_busy, 1'b1);
      check("t4_read_n1", bus.avm_read, 1'b0);
      check("t4_done_n1", prefetch_done, 1'b0);
      @(negedge clk);
      check("t4_done_n2", prefetch_done, 1'b1);
      check("t4_busy_n2", prefetch_busy, 1'b0);
      check("t4_read_n2", bus.avm_read, 1'b0);
      @(negedge clk);
      check("t4_done_n3", prefetch_done, 1'b0);
      check("t4_nreq", req_addr.size(), 0);
      check("t4_nwrites", wq_addr.size(), 0);
      check("t4_done_cnt", done_cnt, 1);

      // Mid-transfer start is ignored; low address bits are dropped
      clear_logs();
      start(30'h4010, 8'd20);
      repeat (8) @(negedge clk);
      cfg_waddr    = 30'h8000;
      cfg_length_w = 8'd3;
      cfg_prefetch = 1'b1;
      @(negedge clk);
      cfg_prefetch = 1'b0;
      wait_done("t5");
      repeat (2) @(negedge clk);
      check("t5_nreq", req_addr.size(), 2);
      check_req("t5", 0, 30'h4000, 5'd16);
      check_req("t5", 1, 30'h4200, 5'd4);
      check_writes("t5", 20);
      check("t5_done_cnt", done_cnt, 1);

      // Asynchronous reset during WAIT, then a clean restart
      clear_logs();
      start(30'h6000, 8'd40);
      begin
         int unsigned n;
         n = 0;
         while (wbuf_we !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check("t6_first_write", wbuf_we, 1'b1);
      end
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_ctrl", {bus.avm_read, bus.avm_address, bus.avm_burstcount, wbuf_we,
                            wbuf_addr, prefetch_busy, prefetch_done}, '0);
      check("t6_rst_data", wbuf_data, '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
      repeat (4) @(negedge clk);
      check("t6_no_done", done_cnt, 0);
      start(30'h5000, 8'd3);
      wait_done("t6");
      @(negedge clk);
      check("t6_nreq", req_addr.size(), 1);
      check_req("t6", 0, 30'h5000, 5'd3);
      check_writes("t6", 3);
      check("t6_done_cnt", done_cnt, 1);
      check("t6_busy_after", prefetch_busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
